// File: rtl/toggle_meter_if.sv
// Measurement bus of the toggle meter: the monitored signal and clear in, edge
// pulses, counts, period and stuck status out.
interface toggle_meter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             q_in;
  logic             clear;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] toggle_cnt;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             stuck;

  modport master (
    output q_in, clear,
    input  rise, fall, toggle_cnt, period, period_valid, stuck
  );

  modport slave (
    input  q_in, clear,
    output rise, fall, toggle_cnt, period, period_valid, stuck
  );
endinterface

// File: rtl/toggle_meter.sv
// Edge detector and activity meter for a toggling T flip-flop output:
// edge pulses, saturating toggle count, rise-to-rise period and stuck flag.
module toggle_meter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STUCK_LIMIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  toggle_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAXV  = '1;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(STUCK_LIMIT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic {
    WAIT_FIRST,
    MEASURING
  } state_t;

  state_t           state;
  logic             q_d;
  logic             rise_r;
  logic             fall_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] period_r;
  logic             pv_r;
  logic             stuck_r;
  logic [WIDTH-1:0] gap;
  logic [WIDTH-1:0] idle;

  logic             rise_det;
  logic             fall_det;
  logic [WIDTH-1:0] idle_nxt;

  always_comb begin
    rise_det = bus.q_in & ~q_d;
    fall_det = ~bus.q_in & q_d;
    idle_nxt = idle;
    if (rise_det || fall_det) begin
      idle_nxt = '0;
    end else if (idle != LIMIT) begin
      idle_nxt = idle + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_FIRST;
      q_d      <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      cnt_r    <= '0;
      period_r <= '0;
      pv_r     <= 1'b0;
      stuck_r  <= 1'b0;
      gap      <= '0;
      idle     <= '0;
    end else begin
      // q_d tracks q_in even under clear so no phantom edge follows it
      q_d <= bus.q_in;
      if (bus.clear) begin
        state    <= WAIT_FIRST;
        rise_r   <= 1'b0;
        fall_r   <= 1'b0;
        cnt_r    <= '0;
        period_r <= '0;
        pv_r     <= 1'b0;
        stuck_r  <= 1'b0;
        gap      <= '0;
        idle     <= '0;
      end else begin
        rise_r  <= rise_det;
        fall_r  <= fall_det;
        idle    <= idle_nxt;
        stuck_r <= (idle_nxt == LIMIT);
        pv_r    <= 1'b0;

        if ((rise_det || fall_det) && cnt_r != MAXV) begin
          cnt_r <= cnt_r + ONE;
        end

        if (rise_det) begin
          gap <= ONE;
        end else if (gap != MAXV) begin
          gap <= gap + ONE;
        end

        case (state)
          WAIT_FIRST: begin
            if (rise_det) begin
              state <= MEASURING;
            end
          end
          MEASURING: begin
            if (rise_det) begin
              period_r <= gap;
              pv_r     <= 1'b1;
            end
          end
          default: state <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign bus.rise         = rise_r;
  assign bus.fall         = fall_r;
  assign bus.toggle_cnt   = cnt_r;
  assign bus.period       = period_r;
  assign bus.period_valid = pv_r;
  assign bus.stuck        = stuck_r;

endmodule

// File: tb/tb_toggle_meter.sv
// Self-checking bench for toggle_meter: directed vector table, directed corner
// sequences and random stimulus against an event-time reference model.
module tb_toggle_meter;

  localparam int WIDTH = 8;
  localparam int LIMIT = 16;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;

  toggle_meter_if #(.WIDTH(WIDTH)) bus ();

  toggle_meter #(.WIDTH(WIDTH), .STUCK_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: works from cycle numbers of events, not counters.
  int n;            // index of the most recent clock edge stepped
  int m_prev;       // q_in seen at the previous edge
  int m_cnt;
  int m_last_rise;  // edge index of last rise since reset/clear, -1 if none
  int m_last_evt;   // edge index of last edge, clear or reset release
  int m_period;
  int m_pv;
  int m_rise;
  int m_fall;
  int m_stuck;

  typedef struct {
    int q;
    int clr;
    int e_rise;
    int e_fall;
    int e_cnt;
    int e_period;
    int e_pv;
    int e_stuck;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_last_rise = -1; m_last_evt = n;
    m_period = 0; m_pv = 0; m_rise = 0; m_fall = 0; m_stuck = 0;
  endtask

  task automatic check_all();
    check("rise",         int'(bus.rise),         m_rise);
    check("fall",         int'(bus.fall),         m_fall);
    check("toggle_cnt",   int'(bus.toggle_cnt),   m_cnt);
    check("period",       int'(bus.period),       m_period);
    check("period_valid", int'(bus.period_valid), m_pv);
    check("stuck",        int'(bus.stuck),        m_stuck);
  endtask

  task automatic step(input int q, input int clr);
    int r;
    int f;
    bus.q_in  = q[0];
    bus.clear = clr[0];
    @(posedge clk);
    n++;
    r = (clr == 0 && q == 1 && m_prev == 0) ? 1 : 0;
    f = (clr == 0 && q == 0 && m_prev == 1) ? 1 : 0;
    m_prev = q;
    if (clr != 0) begin
      m_cnt = 0; m_last_rise = -1; m_period = 0; m_pv = 0; m_last_evt = n;
    end else begin
      m_pv = 0;
      if (r || f) begin
        m_cnt = (m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1;
        m_last_evt = n;
      end
      if (r) begin
        if (m_last_rise >= 0) begin
          m_period = (n - m_last_rise > MAXV) ? MAXV : n - m_last_rise;
          m_pv = 1;
        end
        m_last_rise = n;
      end
    end
    m_rise = r;
    m_fall = f;
    m_stuck = (clr == 0 && (n - m_last_evt) >= LIMIT) ? 1 : 0;
    #1;
    check_all();
  endtask

  // Asserts reset between clock edges, checks outputs clear at once and stay
  // clear across an edge with q_in high, then releases on a falling edge.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    bus.q_in = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 1, 0, 0, 0};  // q_d resets to 0: first edge is a rise
    tbl[1]  = '{0, 0, 0, 1, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 3, 2, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 3, 2, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 4, 2, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 0, 0};  // rise swallowed by clear
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 2, 0, 0, 0};  // first rise after clear
    tbl[9]  = '{0, 0, 0, 1, 3, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 3, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 0, 4, 3, 1, 0};

    n = 0;
    reset = 1'b0;
    bus.q_in = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].q, tbl[i].clr);
      check("tbl_rise",   int'(bus.rise),         tbl[i].e_rise);
      check("tbl_fall",   int'(bus.fall),         tbl[i].e_fall);
      check("tbl_cnt",    int'(bus.toggle_cnt),   tbl[i].e_cnt);
      check("tbl_period", int'(bus.period),       tbl[i].e_period);
      check("tbl_pv",     int'(bus.period_valid), tbl[i].e_pv);
      check("tbl_stuck",  int'(bus.stuck),        tbl[i].e_stuck);
    end

    // Reset mid-stream, then idle low: stuck from the 16th edge-free edge
    async_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      check("idle_stuck", int'(bus.stuck), (i >= LIMIT - 1) ? 1 : 0);
      check("idle_cnt",   int'(bus.toggle_cnt), 0);
    end
    step(1, 0);
    check("post_reset_rise", int'(bus.rise), 1);
    check("post_reset_pv",   int'(bus.period_valid), 0);
    check("stuck_drop",      int'(bus.stuck), 0);

    // Free-running toggle: period 2 on every rise after the first
    step(0, 1);
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 0) ? 1 : 0, 0);
    end
    check("toggle_period", int'(bus.period), 2);
    check("toggle_cnt12",  int'(bus.toggle_cnt), 12);

    // Rises 5 apart, then a 300-cycle gap that saturates period
    step(0, 1);
    for (int i = 0; i < 20; i++) begin
      step((i % 5 == 0) ? 1 : 0, 0);
    end
    check("period5", int'(bus.period), 5);
    for (int i = 0; i < 299; i++) step(0, 0);
    step(1, 0);
    check("period_sat", int'(bus.period), MAXV);
    check("period_sat_pv", int'(bus.period_valid), 1);

    // 300 toggles saturate toggle_cnt
    step(1, 1);
    for (int i = 0; i < 300; i++) begin
      step((i % 2 == 0) ? 0 : 1, 0);
    end
    check("cnt_sat", int'(bus.toggle_cnt), MAXV);

    // Random phases with varying toggle density plus occasional clears
    for (int seg = 0; seg < 16; seg++) begin
      int p;
      int qv;
      p  = (seg % 4 == 0) ? 0 : (seg % 4 == 1) ? 4 : (seg % 4 == 2) ? 50 : 95;
      qv = int'(bus.q_in);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < p) qv = 1 - qv;
        step(qv, ($urandom_range(0, 149) == 0) ? 1 : 0);
      end
      if (seg == 7) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_meter.md
TOGGLE_METER -- requirements
Module: toggle_meter

Interface
REQ-001 Parameter WIDTH, default 8: width of toggle_cnt, period and the internal gap counter.
REQ-002 Parameter STUCK_LIMIT, default 16: number of edge-free clock cycles before stuck asserts; range 1 to 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 q_in  input  1  toggling signal from the upstream T flip-flop Q, synchronous to clk.
REQ-006 clear  input  1  synchronous clear of all measurement state.
REQ-007 rise  output  1  one-cycle pulse per detected rising edge of q_in.
REQ-008 fall  output  1  one-cycle pulse per detected falling edge of q_in.
REQ-009 toggle_cnt  output  WIDTH  saturating count of rising plus falling edges.
REQ-010 period  output  WIDTH  clock cycles between the last two rising edges.
REQ-011 period_valid  output  1  one-cycle pulse when period is updated.
REQ-012 stuck  output  1  level; q_in has not toggled for STUCK_LIMIT cycles.

Function
REQ-013 The block SHALL hold q_d, the value of q_in sampled at the previous clock edge, updated every cycle, including cycles with clear asserted.
REQ-014 A rising edge SHALL be detected at a clock edge where q_in=1 and q_d=0; a falling edge where q_in=0 and q_d=1.
REQ-015 rise/fall SHALL be registered: high for exactly the one cycle following the detecting clock edge; otherwise low.
REQ-016 toggle_cnt SHALL increment by 1 on each detected edge and saturate at 2^WIDTH-1 with no wrap.
REQ-017 The FSM SHALL have two states: WAIT_FIRST (no rising edge since reset/clear) and MEASURING.
REQ-018 WAIT_FIRST -> MEASURING on the first detected rising edge; no period update on that edge.
REQ-019 MEASURING SHALL stay in MEASURING until reset or clear; both return the FSM to WAIT_FIRST.
REQ-020 gap counter: loaded with 1 on every detected rising edge; otherwise incremented by 1, saturating at 2^WIDTH-1.
REQ-021 On a rising edge in MEASURING: period SHALL take the pre-update gap counter value and period_valid SHALL pulse in the same cycle as rise.
REQ-022 Rising edges P clock edges apart SHALL report period=P; gaps of 2^WIDTH-1 or more report 2^WIDTH-1.
REQ-023 period SHALL hold its last value between updates.
REQ-024 idle counter: cleared to 0 on any detected edge; otherwise incremented, saturating at STUCK_LIMIT.
REQ-025 stuck SHALL be high in every cycle where the registered idle counter equals STUCK_LIMIT; this is after STUCK_LIMIT consecutive edge-free clock edges.
REQ-026 stuck SHALL drop in the same cycle that rise or fall pulses.
REQ-027 clear SHALL have priority over edge detection: toggle_cnt, gap counter, idle counter, period, rise, fall, period_valid and stuck go to 0, and FSM goes to WAIT_FIRST at that edge.
REQ-028 An edge coinciding with clear SHALL be neither counted nor pulsed; q_d still captures q_in, so no spurious edge occurs on the next cycle.

Reset
REQ-029 While reset=0, all registers SHALL be 0 (q_d, rise, fall, toggle_cnt, period, period_valid, stuck, gap and idle counters) and the FSM SHALL be in WAIT_FIRST, independent of clk.
REQ-030 Reset asserted mid-measurement SHALL discard all state immediately; no pulses SHALL be produced while reset=0.
REQ-031 If q_in=1 at the first clock edge after reset release, it SHALL be detected as a rising edge, since q_d resets to 0.

Verification
REQ-032 Upstream T held at 0, q_in=0 for 20 cycles after reset -> no rise/fall, toggle_cnt=0, stuck=1 from the 16th edge-free cycle.
REQ-033 q_in toggles every cycle (T=1) -> rise/fall alternate each cycle, period=2 with period_valid on every rise from the 2nd rise, toggle_cnt +1 per cycle, stuck=0.
REQ-034 Rising edges 5 cycles apart -> period=5, period_valid pulses once per rise; then a gap of 300 cycles -> period=255 (WIDTH=8).
REQ-035 300 toggles with WIDTH=8 -> toggle_cnt saturates and holds at 255.
REQ-036 clear asserted in the same cycle as a rising edge -> no rise pulse, all counts 0, FSM in WAIT_FIRST; the next rise gives no period_valid, and the one after it does.
REQ-037 reset driven low asynchronously mid-stream (between clk edges) -> all outputs 0 immediately; after release, first rise produces no period_valid.
